// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: FSM state encoding and default time base.
package freq_meter_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_e;

   localparam int CLK_HZ = 32'd50000000;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Three-flop synchronizer with rising-edge detect for asynchronous key/sensor inputs.
module edge_sync (
   input  logic clkin,
   input  logic clrn,
   input  logic din,
   output logic rise
);

   logic s0_r;
   logic s1_r;
   logic s2_r;

   // s0/s1 resolve metastability; s2 holds the previous settled sample for edge detect
   always_ff @(posedge clkin or negedge clrn) begin
      if (!clrn) begin
         s0_r <= 1'b0;
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s0_r <= din;
         s1_r <= s0_r;
         s2_r <= s1_r;
      end
   end

   assign rise = s1_r & ~s2_r;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous input over a
// GATE_CYCLES-long window and publishes the saturated count with a one-cycle strobe.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int CNT_W       = 16
)(
   input  logic             clkin,
   input  logic             clrn,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             freq_vld,
   output logic             ovf,
   output logic             busy
);

   localparam int             GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [GW-1:0]  GATE_ONE  = GW'(1'b1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   state_e           state_r;
   state_e           state_s;
   logic             win_end_s;
   logic             counting_s;
   logic             rise_s;
   logic             at_max_s;
   logic             ovf_now_s;
   logic [CNT_W-1:0] cnt_next_s;
   logic [GW-1:0]    gate_cnt_r;
   logic [CNT_W-1:0] edge_cnt_r;
   logic             sat_r;
   logic [CNT_W-1:0] freq_r;
   logic             ovf_r;
   logic             vld_r;

   edge_sync u_edge_sync (
      .clkin (clkin),
      .clrn  (clrn),
      .din   (sig_in),
      .rise  (rise_s)
   );

   // Saturating increment shared by in-window counting and the window-end publish
   assign at_max_s   = (edge_cnt_r == CNT_MAX);
   assign ovf_now_s  = rise_s & at_max_s;
   assign cnt_next_s = (rise_s && !at_max_s) ? (edge_cnt_r + CNT_ONE) : edge_cnt_r;

   // Next-state logic and window-end detection
   always_comb begin
      state_s   = state_r;
      win_end_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               state_s = ST_MEASURE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            if (gate_cnt_r == GATE_LAST) begin
               win_end_s = 1'b1;
               state_s   = en ? ST_MEASURE : ST_IDLE;
            end else if (!en) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_MEASURE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Counters advance only mid-window; idle, abort and window end all clear them
   assign counting_s = (state_r == ST_MEASURE) && (state_s == ST_MEASURE) && !win_end_s;

   // FSM state register
   always_ff @(posedge clkin or negedge clrn) begin
      if (!clrn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Gate counter, edge counter and sticky saturation flag
   always_ff @(posedge clkin or negedge clrn) begin
      if (!clrn) begin
         gate_cnt_r <= '0;
         edge_cnt_r <= '0;
         sat_r      <= 1'b0;
      end else if (counting_s) begin
         gate_cnt_r <= gate_cnt_r + GATE_ONE;
         edge_cnt_r <= cnt_next_s;
         sat_r      <= sat_r | ovf_now_s;
      end else begin
         gate_cnt_r <= '0;
         edge_cnt_r <= '0;
         sat_r      <= 1'b0;
      end
   end

   // Published result: an edge in the last gate cycle still belongs to the ending window
   always_ff @(posedge clkin or negedge clrn) begin
      if (!clrn) begin
         freq_r <= '0;
         ovf_r  <= 1'b0;
         vld_r  <= 1'b0;
      end else begin
         vld_r <= win_end_s;
         if (win_end_s) begin
            freq_r <= cnt_next_s;
            ovf_r  <= sat_r | ovf_now_s;
         end else begin
            freq_r <= freq_r;
            ovf_r  <= ovf_r;
         end
      end
   end

   assign freq     = freq_r;
   assign ovf      = ovf_r;
   assign freq_vld = vld_r;
   assign busy     = (state_r == ST_MEASURE);

endmodule
